// File: rtl/stage_fe_pkg.sv
// Shared types and constants for the fetch stage: widths, the NOP word,
// FSM encodings and the queue entry layout.
package stage_fe_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  // addi x0, x0, 0 -- the canonical bubble handed to decode
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  // Fetch FSM encodings, kept as plain constants for legacy tools
  localparam logic [1:0] FE_S_IDLE = 2'd0;
  localparam logic [1:0] FE_S_REQ  = 2'd1;
  localparam logic [1:0] FE_S_WAIT = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fe_entry_t;

  // Instruction addresses are always word aligned; low bits are dropped
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_fe_if.sv
// Instruction-memory port: valid/ready request channel plus a valid-only
// response channel carrying exactly one word per accepted request.
interface stage_fe_if;
  import stage_fe_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [INST_W-1:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );

endinterface

// File: rtl/fe_inst_queue.sv
// Small synchronous FIFO of {pc, inst} pairs between the fetch FSM and the
// decode-facing output register. Clear beats push and pop in the same cycle.
module fe_inst_queue
  import stage_fe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    clear_i,
  input  fe_entry_t               push_data_i,
  output fe_entry_t               head_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fe_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping; power-of-2 depth lets pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: it is only read once the count says it is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/stage_fe.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a
// time, buffers returned words and presents a registered inst/pc/flush slot
// to decode. Redirects from EX kill everything fetched but not yet delivered.
module stage_fe
  import stage_fe_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  stage_fe_if.master        imem,
  output logic [INST_W-1:0] out_inst_o,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic              out_flush_o
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              out_flush_q, out_flush_d;

  logic [CNT_W-1:0]  q_count;
  logic              q_empty;
  fe_entry_t         q_head;
  fe_entry_t         q_push_data;
  logic              q_push;
  logic              q_pop;
  logic              q_clear;
  logic              issue_ok;
  logic              resp_take;

  // Only IDLE can issue, and nothing is in flight there, so occupancy alone
  // decides whether the returning word is guaranteed a free slot.
  assign issue_ok  = (q_count < CNT_W'(QUEUE_DEPTH));
  assign resp_take = (state_q == FE_S_WAIT) && imem.resp_valid;

  assign imem.req_valid = (state_q == FE_S_REQ);
  assign imem.req_addr  = addr_q;

  // The request address doubles as the PC of the returning word
  assign q_push_data = '{pc: addr_q, inst: imem.resp_data};
  assign q_push      = en_i && resp_take && !drop_q && !redirect_i;
  assign q_pop       = en_i && !stall_i && !redirect_i && !q_empty;
  assign q_clear     = en_i && redirect_i;

  assign out_inst_o  = out_inst_q;
  assign out_pc_o    = out_pc_q;
  assign out_flush_o = out_flush_q;

  fe_inst_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push_i     (q_push),
    .pop_i      (q_pop),
    .clear_i    (q_clear),
    .push_data_i(q_push_data),
    .head_o     (q_head),
    .count_o    (q_count),
    .empty_o    (q_empty)
  );

  // Fetch FSM, PC advance and the drop flag that kills a word already in flight
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    case (state_q)
      FE_S_IDLE: begin
        if (!redirect_i && issue_ok) begin
          state_d = FE_S_REQ;
          addr_d  = pc_q;
        end
      end
      FE_S_REQ: begin
        if (imem.req_ready) begin
          state_d = FE_S_WAIT;
          // After an earlier redirect the PC already holds the new target
          if (!redirect_i && !drop_q) begin
            pc_d = pc_q + ADDR_W'(4);
          end
        end
      end
      FE_S_WAIT: begin
        if (imem.resp_valid) begin
          state_d = FE_S_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d = FE_S_IDLE;
      end
    endcase
    if (redirect_i) begin
      pc_d = align_word(redirect_pc_i);
      if ((state_q == FE_S_REQ) || ((state_q == FE_S_WAIT) && !imem.resp_valid)) begin
        drop_d = 1'b1;
      end
    end
  end

  // Decode-facing slot: redirect forces a bubble, stall holds, otherwise pop or bubble
  always_comb begin
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_flush_d = out_flush_q;
    if (redirect_i) begin
      out_inst_d  = INST_NOP;
      out_flush_d = 1'b1;
    end else if (!stall_i) begin
      if (!q_empty) begin
        out_inst_d  = q_head.inst;
        out_pc_d    = q_head.pc;
        out_flush_d = 1'b0;
      end else begin
        out_inst_d  = INST_NOP;
        out_flush_d = 1'b1;
      end
    end
  end

  // State registers: reset wins, then the global enable gates every update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FE_S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      drop_q      <= 1'b0;
      out_inst_q  <= INST_NOP;
      out_pc_q    <= RESET_PC;
      out_flush_q <= 1'b1;
    end else if (en_i) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      drop_q      <= drop_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_flush_q <= out_flush_d;
    end
  end

endmodule

// File: tb/tb_stage_fe.sv
// Directed bench for stage_fe: a vector table for straight-line fetch and
// stall back-pressure, then hand-written sequences for redirects, reset in
// flight and the global enable. A small memory model answers requests.
module tb_stage_fe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        expValid;
    logic [31:0] expAddr;
    logic        expFlush;
    logic [31:0] expPc;
    logic [31:0] expInst;
  } vecT;

  logic        clk;
  logic        rst;
  logic        en;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [31:0] outInst;
  logic [31:0] outPc;
  logic        outFlush;

  int          errors;
  int          checks;

  // Memory model state
  int          memLat;
  logic [31:0] deadAddr;
  logic        accSeen;
  logic        respSeen;
  logic        rstSeen;
  logic [31:0] accAddr;
  logic        pend;
  int          delay;
  logic [31:0] pendData;
  int          respDelivered;

  vecT         vecs [28];

  stage_fe_if memIf ();

  stage_fe #(
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirectPc),
    .imem         (memIf),
    .out_inst_o   (outInst),
    .out_pc_o     (outPc),
    .out_flush_o  (outFlush)
  );

  // Free-running core clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == deadAddr) return 32'h0000_DEAD;
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory model, sample side: note accepts and consumed responses at the edge
  always @(posedge clk) begin
    rstSeen  = rst;
    accSeen  = !rst && en && memIf.req_valid && memIf.req_ready;
    accAddr  = memIf.req_addr;
    respSeen = !rst && en && memIf.resp_valid;
    if (respSeen) respDelivered++;
  end

  // Memory model, drive side: answer memLat cycles after accept; reset drops it
  always @(negedge clk) begin
    if (rstSeen) begin
      pend             = 1'b0;
      memIf.resp_valid = 1'b0;
    end else begin
      if (respSeen) memIf.resp_valid = 1'b0;
      if (accSeen) begin
        pend     = 1'b1;
        delay    = memLat;
        pendData = memData(accAddr);
      end
      if (pend) begin
        delay--;
        if (delay == 0) begin
          memIf.resp_valid = 1'b1;
          memIf.resp_data  = pendData;
          pend             = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc,
                               input logic rdy);
    @(negedge clk);
    stall           = s;
    redirect        = r;
    redirectPc      = rpc;
    memIf.req_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic expValid, input logic [31:0] expAddr,
                             input logic expFlush, input logic [31:0] expPc, input logic chkPc,
                             input logic [31:0] expInst);
    checks++;
    if (memIf.req_valid !== expValid) begin
      errors++;
      $display("[TB] FAIL %s req_valid: got %0b want %0b", name, memIf.req_valid, expValid);
    end
    if (expValid) begin
      checks++;
      if (memIf.req_addr !== expAddr) begin
        errors++;
        $display("[TB] FAIL %s req_addr: got %h want %h", name, memIf.req_addr, expAddr);
      end
    end
    checks++;
    if (outFlush !== expFlush) begin
      errors++;
      $display("[TB] FAIL %s out_flush: got %0b want %0b", name, outFlush, expFlush);
    end
    checks++;
    if (outInst !== expInst) begin
      errors++;
      $display("[TB] FAIL %s out_inst: got %h want %h", name, outInst, expInst);
    end
    if (chkPc) begin
      checks++;
      if (outPc !== expPc) begin
        errors++;
        $display("[TB] FAIL %s out_pc: got %h want %h", name, outPc, expPc);
      end
    end
  endtask

  // One cycle of stimulus followed by the check of the registered result
  task automatic step(input string name, input logic s, input logic r, input logic [31:0] rpc,
                      input logic rdy, input logic expValid, input logic [31:0] expAddr,
                      input logic expFlush, input logic [31:0] expPc, input logic [31:0] expInst);
    applyStimulus(s, r, rpc, rdy);
    checkOutput(name, expValid, expAddr, expFlush, expPc, !expFlush, expInst);
  endtask

  task automatic runRows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].stall, 1'b0, 32'h0, vecs[i].ready);
      checkOutput($sformatf("row%0d", i), vecs[i].expValid, vecs[i].expAddr,
                  vecs[i].expFlush, vecs[i].expPc, 1'b1, vecs[i].expInst);
    end
  endtask

  initial begin
    int respBefore;
    errors           = 0;
    checks           = 0;
    memLat           = 1;
    deadAddr         = 32'hFFFF_FFFF;
    pend             = 1'b0;
    delay            = 0;
    respDelivered    = 0;
    rstSeen          = 1'b1;
    accSeen          = 1'b0;
    respSeen         = 1'b0;
    rst              = 1'b1;
    en               = 1'b1;
    stall            = 1'b0;
    redirect         = 1'b0;
    redirectPc       = 32'h0;
    memIf.req_ready  = 1'b0;
    memIf.resp_valid = 1'b0;
    memIf.resp_data  = 32'h0;

    // Straight-line fetch, one word every three cycles with 1-cycle memory
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h00, NOP};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, NOP};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, NOP};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'hC0DE_0000};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, NOP};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, NOP};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b0, 32'h04, 32'hC0DE_0004};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h04, NOP};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h04, NOP};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h08, 32'hC0DE_0008};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08, NOP};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08, NOP};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0C, 32'hC0DE_000C};
    // Ten stalled cycles: outputs frozen, queue fills to two, then no requests
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0C, 32'hC0DE_000C};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0C, 32'hC0DE_000C};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h0C, 32'hC0DE_000C};
    for (int i = 16; i <= 22; i++) begin
      vecs[i] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0C, 32'hC0DE_000C};
    end
    // Release: both queued words drain in order, then fetch resumes
    vecs[23] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h10, 32'hC0DE_0010};
    vecs[24] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b0, 32'h14, 32'hC0DE_0014};
    vecs[25] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h14, NOP};
    vecs[26] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h14, NOP};
    vecs[27] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h18, 32'hC0DE_0018};

    $display("[TB] reset for three cycles");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset", 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, NOP);
    end
    rst = 1'b0;

    $display("[TB] straight-line fetch");
    runRows(0, 12);

    $display("[TB] stall with queue back-pressure");
    respBefore = respDelivered;
    runRows(13, 22);
    checks++;
    if (respDelivered - respBefore != 2) begin
      errors++;
      $display("[TB] FAIL stallFetched: got %0d words want 2", respDelivered - respBefore);
    end
    runRows(23, 27);

    $display("[TB] redirect while waiting, late DEAD word");
    memLat   = 3;
    deadAddr = 32'h1C;
    step("w6",  0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   NOP);
    step("w7",  0, 1, 32'h100, 1, 0, 32'h0,   1, 32'h0,   NOP);
    step("w8",  0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   NOP);
    memLat = 1;
    step("w9",  0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   NOP);
    step("w10", 0, 0, 32'h0,   1, 1, 32'h100, 1, 32'h0,   NOP);
    step("w11", 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   NOP);
    step("w12", 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   NOP);
    step("w13", 0, 0, 32'h0,   1, 1, 32'h104, 0, 32'h100, 32'hC0DE_0100);

    $display("[TB] redirect in the same cycle as the response");
    step("s14", 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   NOP);
    step("s15", 0, 1, 32'h200, 1, 0, 32'h0,   1, 32'h0,   NOP);
    step("s16", 0, 0, 32'h0,   1, 1, 32'h200, 1, 32'h0,   NOP);
    step("s17", 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   NOP);
    step("s18", 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   NOP);
    step("s19", 0, 0, 32'h0,   1, 1, 32'h204, 0, 32'h200, 32'hC0DE_0200);

    $display("[TB] redirect while request is held by ready=0");
    step("q1",  0, 1, 32'h303, 0, 1, 32'h204, 1, 32'h0,   NOP);
    step("q2",  0, 0, 32'h0,   0, 1, 32'h204, 1, 32'h0,   NOP);
    step("q3",  0, 0, 32'h0,   0, 1, 32'h204, 1, 32'h0,   NOP);
    step("q4",  0, 0, 32'h0,   0, 1, 32'h204, 1, 32'h0,   NOP);
    step("q5",  0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   NOP);
    step("q6",  0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   NOP);
    step("q7",  0, 0, 32'h0,   1, 1, 32'h300, 1, 32'h0,   NOP);
    step("q8",  0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   NOP);
    step("q9",  0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   NOP);
    step("q10", 0, 0, 32'h0,   1, 1, 32'h304, 0, 32'h300, 32'hC0DE_0300);

    $display("[TB] reset during an outstanding request");
    memLat = 3;
    step("q11", 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0, NOP);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("rstWait", 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, NOP);
    end
    rst    = 1'b0;
    memLat = 1;
    step("e1", 0, 0, 32'h0, 1, 1, 32'h0, 1, 32'h0, NOP);
    step("e2", 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0, NOP);
    step("e3", 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0, NOP);
    step("e4", 0, 0, 32'h0, 1, 1, 32'h4, 0, 32'h0, 32'hC0DE_0000);

    $display("[TB] global enable low for five cycles");
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step($sformatf("frz%0d", i), 0, 0, 32'h0, 1, 1, 32'h4, 0, 32'h0, 32'hC0DE_0000);
    end
    en = 1'b1;
    step("h1", 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0, NOP);
    step("h2", 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0, NOP);
    step("h3", 0, 0, 32'h0, 1, 1, 32'h8, 0, 32'h4, 32'hC0DE_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
